// File: rtl/alu_cmd_queue.sv
// alu_cmd_queue: FIFO-buffered issue stage for a combinational ALU, with a
// registered result slot toward the consumer and a saturating error count.
module alu_cmd_queue #(
    parameter int N     = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_op1,
    input  logic [N-1:0]     in_op2,
    input  logic [3:0]       in_cmd,
    output logic [N-1:0]     alu_op1,
    output logic [N-1:0]     alu_op2,
    output logic [3:0]       alu_cmd,
    input  logic [N-1:0]     alu_out,
    input  logic             alu_over,
    input  logic             alu_under,
    input  logic             alu_err,
    input  logic             alu_log,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [N-1:0]     res_out,
    output logic             res_over,
    output logic             res_under,
    output logic             res_err,
    output logic             res_log,
    output logic [3:0]       res_cmd,
    output logic [CNT_W-1:0] err_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [N-1:0]     r_op1 [DEPTH];
    logic [N-1:0]     r_op2 [DEPTH];
    logic [3:0]       r_cmd [DEPTH];
    logic [AW-1:0]    r_wp, r_rp;
    logic [CW-1:0]    r_cnt;
    logic             r_valid, r_over, r_under, r_err, r_log;
    logic [N-1:0]     r_out;
    logic [3:0]       r_res_cmd;
    logic [CNT_W-1:0] r_err_cnt;
    logic             w_empty, w_push, w_load;
    always_comb begin
        w_empty   = r_cnt == '0;
        in_ready  = r_cnt != CW'(DEPTH);
        w_push    = in_valid && in_ready;
        w_load    = !w_empty && (!r_valid || res_ready);
        alu_op1   = w_empty ? '0 : r_op1[r_rp];
        alu_op2   = w_empty ? '0 : r_op2[r_rp];
        alu_cmd   = w_empty ? '0 : r_cmd[r_rp];
        res_valid = r_valid;
        res_out   = r_out;
        res_over  = r_over;
        res_under = r_under;
        res_err   = r_err;
        res_log   = r_log;
        res_cmd   = r_res_cmd;
        err_cnt   = r_err_cnt;
    end
    // Entry storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_op1[r_wp] <= in_op1;
            r_op2[r_wp] <= in_op2;
            r_cmd[r_wp] <= in_cmd;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp      <= '0;
            r_rp      <= '0;
            r_cnt     <= '0;
            r_valid   <= 1'b0;
            r_out     <= '0;
            r_over    <= 1'b0;
            r_under   <= 1'b0;
            r_err     <= 1'b0;
            r_log     <= 1'b0;
            r_res_cmd <= '0;
            r_err_cnt <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + AW'(1);
            if (w_load) r_rp <= r_rp + AW'(1);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_load);
            if (w_load) begin
                r_valid   <= 1'b1;
                r_out     <= alu_out;
                r_over    <= alu_over;
                r_under   <= alu_under;
                r_err     <= alu_err;
                r_log     <= alu_log;
                r_res_cmd <= alu_cmd;
            end else if (r_valid && res_ready) begin
                r_valid <= 1'b0;
            end
            if (w_load && alu_err && r_err_cnt != '1) r_err_cnt <= r_err_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_alu_cmd_queue.sv
// tb_alu_cmd_queue: randomized and directed checks of alu_cmd_queue against a
// queue-based reference model, with a behavioural ALU driving both instances.
module tb_alu_cmd_queue;
    localparam int DEPTH = 4;
    typedef struct packed {
        logic [7:0] out;
        logic       over, under, err, log;
        logic [3:0] cmd;
    } res_t;
    typedef struct packed {
        logic [7:0] a, b;
        logic [3:0] c;
    } req_t;

    logic       clk = 0, rst = 1, in_valid = 0, res_ready = 0;
    logic [7:0] in_op1 = 0, in_op2 = 0;
    logic [3:0] in_cmd = 0;
    logic       in_ready, res_valid, res_over, res_under, res_err, res_log;
    logic [7:0] alu_op1, alu_op2, res_out, err_cnt;
    logic [3:0] alu_cmd, res_cmd;
    logic       s_in_ready, s_res_valid, s_res_over, s_res_under, s_res_err, s_res_log;
    logic [7:0] s_alu_op1, s_alu_op2, s_res_out;
    logic [3:0] s_alu_cmd, s_res_cmd;
    logic [1:0] s_err_cnt;
    res_t       a_r, s_r, dut_r;

    function automatic res_t alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c);
        res_t       r;
        logic [8:0] s;
        r = '0;
        r.cmd = c;
        s = {1'b0, a} + {1'b0, b};
        case (c)
            4'd0: begin r.out = s[7:0]; r.over = s[8]; end
            4'd1: begin r.out = a - b; r.under = a < b; end
            4'd2: r.out = a & b;
            4'd3: r.out = a | b;
            4'd4: r.log = a == b;
            4'd5: r.out = a ^ b;
            4'd6: r.log = a < b;
            4'd7: r.log = a > b;
            4'd8: r.out = ~a;
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

    assign a_r   = alu_f(alu_op1, alu_op2, alu_cmd);
    assign s_r   = alu_f(s_alu_op1, s_alu_op2, s_alu_cmd);
    assign dut_r = {res_out, res_over, res_under, res_err, res_log, res_cmd};

    alu_cmd_queue #(.N(8), .DEPTH(DEPTH), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_op1(in_op1), .in_op2(in_op2), .in_cmd(in_cmd),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_cmd(alu_cmd),
        .alu_out(a_r.out), .alu_over(a_r.over), .alu_under(a_r.under),
        .alu_err(a_r.err), .alu_log(a_r.log),
        .res_valid(res_valid), .res_ready(res_ready), .res_out(res_out),
        .res_over(res_over), .res_under(res_under), .res_err(res_err),
        .res_log(res_log), .res_cmd(res_cmd), .err_cnt(err_cnt)
    );

    alu_cmd_queue #(.N(8), .DEPTH(DEPTH), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_op1(in_op1), .in_op2(in_op2), .in_cmd(in_cmd),
        .alu_op1(s_alu_op1), .alu_op2(s_alu_op2), .alu_cmd(s_alu_cmd),
        .alu_out(s_r.out), .alu_over(s_r.over), .alu_under(s_r.under),
        .alu_err(s_r.err), .alu_log(s_r.log),
        .res_valid(s_res_valid), .res_ready(res_ready), .res_out(s_res_out),
        .res_over(s_res_over), .res_under(s_res_under), .res_err(s_res_err),
        .res_log(s_res_log), .res_cmd(s_res_cmd), .err_cnt(s_err_cnt)
    );

    always #5 clk = ~clk;

    req_t mq[$];
    res_t exp_q[$], got_q[$];
    logic m_valid = 0;
    res_t m_slot = '0;
    int   m_err = 0, m_sat = 0;
    int   total = 0, bad = 0;

    // Drive one cycle of inputs, advance the reference model, then sample 1ns after the edge.
    task automatic cycle(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] c, input logic rr);
        req_t q;
        bit   push, load;
        in_valid = v; in_op1 = a; in_op2 = b; in_cmd = c; res_ready = rr;
        if (rst) begin
            mq.delete(); exp_q.delete(); got_q.delete();
            m_valid = 0; m_slot = '0; m_err = 0; m_sat = 0;
        end else begin
            if (res_valid && rr) got_q.push_back(dut_r);
            push = v && mq.size() < DEPTH;
            load = mq.size() > 0 && (!m_valid || rr);
            if (load) begin
                q = mq.pop_front();
                m_slot = alu_f(q.a, q.b, q.c);
                m_valid = 1;
                if (m_slot.err) begin
                    m_err = m_err < 255 ? m_err + 1 : 255;
                    m_sat = m_sat < 3 ? m_sat + 1 : 3;
                end
            end else if (m_valid && rr) begin
                m_valid = 0;
            end
            if (push) begin
                mq.push_back(req_t'({a, b, c}));
                exp_q.push_back(alu_f(a, b, c));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        cycle(0, 0, 0, 0, 0);
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", res_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL reset_err_cnt got=%0d exp=0", err_cnt); end
        total++; if (dut_r !== '0) begin bad++; $display("FAIL reset_slot got=%h exp=0", dut_r); end
        total++; if ({alu_op1, alu_op2, alu_cmd} !== 20'h0) begin bad++; $display("FAIL reset_alu_in got=%h exp=0", {alu_op1, alu_op2, alu_cmd}); end
    endtask

    task automatic test_basic_add();
        cycle(1, 200, 100, 0, 1);
        total++; if ({alu_op1, alu_op2} !== {8'd200, 8'd100}) begin bad++; $display("FAIL add_head got=%0d,%0d exp=200,100", alu_op1, alu_op2); end
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL add_early_valid got=%b exp=0", res_valid); end
        cycle(0, 0, 0, 0, 1);
        total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b exp=1", res_valid); end
        total++; if (res_out !== 8'd44 || res_over !== 1'b1) begin bad++; $display("FAIL add_result got=%0d over=%b exp=44 over=1", res_out, res_over); end
        total++; if ({res_under, res_err, res_log, res_cmd} !== 7'h0) begin bad++; $display("FAIL add_flags got=%h exp=0", {res_under, res_err, res_log, res_cmd}); end
        cycle(0, 0, 0, 0, 1);
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL add_drain got=%b exp=0", res_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] eo[3] = '{8'd254, 8'd0, 8'd0};
        logic       eu[3] = '{1'b1, 1'b0, 1'b0};
        logic       el[3] = '{1'b0, 1'b1, 1'b1};
        logic [3:0] ec[3] = '{4'd1, 4'd4, 4'd6};
        cycle(1, 5, 7, 1, 1);
        for (int i = 0; i < 3; i++) begin
            if (i == 0) cycle(1, 9, 9, 4, 1);
            else if (i == 1) cycle(1, 3, 8, 6, 1);
            else cycle(0, 0, 0, 0, 1);
            total++;
            if (res_valid !== 1'b1 || res_out !== eo[i] || res_under !== eu[i] || res_log !== el[i] || res_cmd !== ec[i]) begin
                bad++;
                $display("FAIL burst_%0d got=v%b out%0d u%b l%b c%0d exp=v1 out%0d u%b l%b c%0d",
                         i, res_valid, res_out, res_under, res_log, res_cmd, eo[i], eu[i], el[i], ec[i]);
            end
        end
        cycle(0, 0, 0, 0, 1);
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL burst_drain got=%b exp=0", res_valid); end
    endtask

    task automatic test_backpressure();
        req_t r[6];
        got_q.delete();
        for (int i = 0; i < 6; i++) r[i] = req_t'({8'($urandom), 8'($urandom), 4'($urandom_range(0, 8))});
        for (int i = 0; i < 6; i++) begin
            cycle(1, r[i].a, r[i].b, r[i].c, 0);
            if (i == 4) begin
                total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full got=%b exp=0", in_ready); end
            end
        end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_refuse got=%b exp=0", in_ready); end
        cycle(0, 0, 0, 0, 0);
        total++; if (res_valid !== 1'b1 || dut_r !== alu_f(r[0].a, r[0].b, r[0].c)) begin bad++; $display("FAIL bp_hold got=%h exp=%h", dut_r, alu_f(r[0].a, r[0].b, r[0].c)); end
        for (int j = 1; j <= 5; j++) begin
            cycle(0, 0, 0, 0, 1);
            if (j < 5) begin
                total++; if (res_valid !== 1'b1 || dut_r !== alu_f(r[j].a, r[j].b, r[j].c)) begin bad++; $display("FAIL bp_drain_%0d got=v%b %h exp=%h", j, res_valid, dut_r, alu_f(r[j].a, r[j].b, r[j].c)); end
            end else begin
                total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL bp_end got=%b exp=0", res_valid); end
            end
        end
        total++; if (got_q.size() != 5) begin bad++; $display("FAIL bp_count got=%0d exp=5", got_q.size()); end
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            total++; if (got_q[i] !== alu_f(r[i].a, r[i].b, r[i].c)) begin bad++; $display("FAIL bp_order_%0d got=%h exp=%h", i, got_q[i], alu_f(r[i].a, r[i].b, r[i].c)); end
        end
    endtask

    task automatic test_err_count();
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, 8'(i), 8'(i + 1), 9, 1);
        repeat (2) cycle(0, 0, 0, 0, 1);
        total++; if (got_q.size() != 3) begin bad++; $display("FAIL err_results got=%0d exp=3", got_q.size()); end
        foreach (got_q[i]) begin
            total++; if (got_q[i].err !== 1'b1) begin bad++; $display("FAIL err_flag_%0d got=%b exp=1", i, got_q[i].err); end
        end
        total++; if (err_cnt !== 8'd3) begin bad++; $display("FAIL err_cnt3 got=%0d exp=3", err_cnt); end
        total++; if (s_err_cnt !== 2'd3) begin bad++; $display("FAIL sat_cnt3 got=%0d exp=3", s_err_cnt); end
        for (int i = 0; i < 2; i++) cycle(1, 8'd1, 8'd2, 4'($urandom_range(9, 15)), 1);
        repeat (2) cycle(0, 0, 0, 0, 1);
        total++; if (err_cnt !== 8'd5) begin bad++; $display("FAIL err_cnt5 got=%0d exp=5", err_cnt); end
        total++; if (s_err_cnt !== 2'd3) begin bad++; $display("FAIL sat_hold got=%0d exp=3", s_err_cnt); end
    endtask

    task automatic test_wrap();
        int  sent = 0, cyc = 0;
        logic v;
        do_reset();
        while ((sent < 3 * DEPTH + 1 || mq.size() > 0 || m_valid) && cyc < 500) begin
            v = sent < 3 * DEPTH + 1 && $urandom_range(0, 3) != 0;
            if (v && mq.size() < DEPTH) sent++;
            cycle(v, 8'($urandom), 8'($urandom), 4'($urandom), 1'($urandom));
            cyc++;
            total++; if (res_valid !== m_valid) begin bad++; $display("FAIL wrap_valid cyc=%0d got=%b exp=%b", cyc, res_valid, m_valid); end
            total++; if (in_ready !== (mq.size() != DEPTH)) begin bad++; $display("FAIL wrap_ready cyc=%0d got=%b exp=%b", cyc, in_ready, mq.size() != DEPTH); end
            if (m_valid) begin
                total++; if (dut_r !== m_slot) begin bad++; $display("FAIL wrap_slot cyc=%0d got=%h exp=%h", cyc, dut_r, m_slot); end
            end
            total++; if (err_cnt !== 8'(m_err)) begin bad++; $display("FAIL wrap_err_cnt cyc=%0d got=%0d exp=%0d", cyc, err_cnt, m_err); end
        end
        total++; if (cyc >= 500) begin bad++; $display("FAIL wrap_timeout got=%0d cycles exp<500", cyc); end
        total++; if (got_q.size() != 3 * DEPTH + 1 || exp_q.size() != 3 * DEPTH + 1) begin bad++; $display("FAIL wrap_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL wrap_order_%0d got=%h exp=%h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        cycle(1, 1, 2, 9, 0);
        for (int i = 0; i < 3; i++) cycle(1, 8'($urandom), 8'($urandom), 4'($urandom_range(0, 8)), 0);
        total++; if (res_valid !== 1'b1 || err_cnt !== 8'd1 || in_ready !== 1'b1) begin bad++; $display("FAIL mid_pre got=v%b e%0d r%b exp=v1 e1 r1", res_valid, err_cnt, in_ready); end
        do_reset();
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b exp=0", res_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b exp=1", in_ready); end
        total++; if (err_cnt !== 8'd0) begin bad++; $display("FAIL mid_err_cnt got=%0d exp=0", err_cnt); end
        cycle(1, 11, 22, 0, 1);
        repeat (3) cycle(0, 0, 0, 0, 1);
        total++; if (got_q.size() != 1) begin bad++; $display("FAIL mid_count got=%0d exp=1", got_q.size()); end
        if (got_q.size() > 0) begin
            total++; if (got_q[0].out !== 8'd33 || got_q[0].cmd !== 4'd0 || got_q[0].over !== 1'b0) begin bad++; $display("FAIL mid_result got=%h exp out=33 cmd=0", got_q[0]); end
        end
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL mid_end got=%b exp=0", res_valid); end
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_back_to_back();
        test_backpressure();
        test_err_count();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alu_cmd_queue.md
Name: alu_cmd_queue

Overview:
Upstream issue stage for the N-bit combinational ALU. It buffers operation requests (op1, op2, cmd) from a valid/ready producer in a DEPTH-entry FIFO and drives the FIFO head onto the ALU inputs. It captures the ALU result and flags into a registered output slot with a valid/ready handshake toward the consumer. It also keeps a saturating count of error results.

Parameters:
N, 8, operand/result width; must match the ALU's N
DEPTH, 4, FIFO entries; power of two, >= 2
CNT_W, 8, width of err_cnt

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  request present
in_ready  output  1  FIFO can accept
in_op1  input  N  operand 1
in_op2  input  N  operand 2
in_cmd  input  4  ALU command code
alu_op1  output  N  to ALU op1; FIFO head operand 1
alu_op2  output  N  to ALU op2; FIFO head operand 2
alu_cmd  output  4  to ALU cmd; FIFO head command
alu_out  input  N  from ALU out
alu_over  input  1  from ALU over
alu_under  input  1  from ALU under
alu_err  input  1  from ALU err
alu_log  input  1  from ALU log
res_valid  output  1  result slot full
res_ready  input  1  consumer takes result
res_out  output  N  registered result
res_over  output  1  registered flag
res_under  output  1  registered flag
res_err  output  1  registered flag
res_log  output  1  registered flag
res_cmd  output  4  command that produced the result
err_cnt  output  CNT_W  saturating count of loaded results with err=1

Behaviour:
- One clock, clk; reset synchronous, active-high, name rst. While rst=1 at a rising edge, every output register clears:
  - FIFO pointers and count = 0, so the FIFO is empty.
  - res_valid = 0; res_out, all res flags, res_cmd = 0; err_cnt = 0.
  - Reset mid-operation discards all queued entries and any held result.
- in_ready = (count != DEPTH). This is combinational from state only, not from in_valid or res_ready.
- Push: in_valid && in_ready at an edge writes {in_op1, in_op2, in_cmd} at the write pointer. The write pointer wraps modulo DEPTH.
- alu_op1/op2/cmd are driven combinationally from the head entry. When the FIFO is empty they are driven to 0; their value is don't-care to the consumer.
- Load condition: load = (count != 0) && (!res_valid || res_ready).
- On load at an edge:
  - Result slot <= {alu_out, alu_over, alu_under, alu_err, alu_log, head cmd}.
  - res_valid <= 1; the head is popped and the read pointer wraps modulo DEPTH.
- If res_valid && res_ready && count == 0: res_valid <= 0. Data registers hold their value.
- If res_valid && !res_ready: the slot holds all fields stable; no pop occurs.
- Simultaneous push and pop in one cycle: count is unchanged and both pointers advance.
  - A full FIFO refuses a push even if a pop occurs in the same cycle; there is no bypass.
  - An empty FIFO cannot pop in the same cycle it is written.
- Latency: a request accepted at edge k appears with res_valid=1 after edge k+1 when the slot is free. Throughput is 1 result/cycle with res_ready held at 1.
- Ordering is strict FIFO; no request is dropped or duplicated.
- err_cnt increments on every load with alu_err=1 and saturates at 2^CNT_W-1 (no wrap). It is cleared only by rst.
- The result captured is the ALU's combinational response to the head entry in the same cycle. This block adds no arithmetic of its own.

Test Plan:
- Basic add: push (200, 100, 0) into an idle queue with res_ready=1 -> one cycle later res_valid=1, res_out=44, res_over=1, res_cmd=0, other flags 0.
- Sub and compare burst: push (5,7,1), (9,9,4), (3,8,6) back-to-back -> three consecutive results: (254, under=1), (0, log=1), (0, log=1), in order.
- Backpressure/full: res_ready=0 and push 5 requests with DEPTH=4 -> the first loads into the slot and 4 fill the FIFO. in_ready=0, the 6th push is refused, and the slot stays stable. Then release res_ready -> all 5 results emerge in order, one per cycle.
- Error counting: push cmd=9 three times -> res_err=1 on each and err_cnt=3. With CNT_W=2 and 5 error commands -> err_cnt stays at 3.
- Pointer wrap: stream 3*DEPTH+1 requests with a random res_ready pattern -> the output sequence matches a reference model exactly and no entry is lost.
- Reset mid-stream: assert rst for 1 cycle with 3 entries queued and res_valid=1 -> next cycle res_valid=0, in_ready=1, err_cnt=0. The next push yields only its own result.
